// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared key/wave constants and the wave-select helper for the dds slice
package dds_pkg;

  localparam int KEY_NUM = 4;

  typedef logic [KEY_NUM-1:0] wave_t;

  localparam wave_t WAVE_NONE     = 4'b0000;
  localparam wave_t WAVE_SINE     = 4'b0001;
  localparam wave_t WAVE_SQUARE   = 4'b0010;
  localparam wave_t WAVE_TRIANGLE = 4'b0100;
  localparam wave_t WAVE_SAWTOOTH = 4'b1000;

  // Lowest set bit wins when several keys are accepted on the same cycle.
  function automatic wave_t lowest_set(input wave_t p);
    wave_t r;
    r = WAVE_NONE;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (p[i]) begin
        r    = WAVE_NONE;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_filter.sv
// rtl/key_filter.sv - one push-button: 2-flop synchronizer, debounce counter, single press pulse
module key_filter #(
  parameter int CNT_MAX = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic pulse
);

  localparam int            CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_ARM = CW'(CNT_MAX - 2);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], key};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (sync[1]) begin
      cnt <= '0;
    end else if (cnt < CNT_TOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the step CNT_MAX-2 -> CNT_MAX-1; saturation keeps a held key from re-firing.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pulse <= 1'b0;
    end else begin
      pulse <= !sync[1] && (cnt == CNT_ARM);
    end
  end

endmodule

// File: rtl/key_control.sv
// rtl/key_control.sv - debounced key array driving the one-hot dds wave select
// WAVE_TOGGLE_OFF_EN: re-pressing the selected key clears the selection instead of keeping it.
module key_control
  import dds_pkg::*;
#(
  parameter int CNT_MAX = 999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] wave_sel,
  output logic               key_flag
);

  wave_t pulse;
  wave_t pick;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_filter #(
      .CNT_MAX(CNT_MAX)
    ) u_key_filter (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key      (key[i]),
      .pulse    (pulse[i])
    );
  end

  assign pick = lowest_set(pulse);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wave_sel <= WAVE_NONE;
      key_flag <= 1'b0;
    end else begin
      key_flag <= |pulse;
      if (|pulse) begin
`ifdef WAVE_TOGGLE_OFF_EN
        wave_sel <= (wave_sel == pick) ? WAVE_NONE : pick;
`else
        wave_sel <= pick;
`endif
      end
    end
  end

endmodule

// File: tb/tb_key_control.sv
// tb/tb_key_control.sv - randomized and directed scoreboard bench for key_control (CNT_MAX=20)
module tb_key_control;

  localparam int CNT_MAX = 20;
  localparam int LAT     = CNT_MAX + 2;

  typedef struct {
    int         cyc;
    logic [3:0] wave;
  } ev_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] wave_sel;
  logic       key_flag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int flag_count = 0;
  int last_flag_cyc = -1;

  ev_t        sbq[$];
  int         run[4];
  logic [3:0] pipe[3];
  logic [3:0] model_wave = 4'b0000;

  key_control #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .wave_sel (wave_sel),
    .key_flag (key_flag)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a key is accepted once it has been sampled low CNT_MAX-1 edges in a row;
  // the selection changes three edges later (two sync stages plus the output register).
  always @(posedge sys_clk) begin
    logic [3:0] acc;
    logic [3:0] out;
    logic [3:0] onehot;
    cyc++;
    if (!sys_rst_n) begin
      for (int i = 0; i < 4; i++) run[i] = 0;
      for (int i = 0; i < 3; i++) pipe[i] = 4'b0000;
      model_wave = 4'b0000;
    end else begin
      acc = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (key[i]) run[i] = 0;
        else if (run[i] < CNT_MAX) run[i] = run[i] + 1;
        if (!key[i] && run[i] == CNT_MAX - 1) acc[i] = 1'b1;
      end
      out     = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = acc;
      if (out != 4'b0000) begin
        onehot = 4'b0000;
        for (int i = 3; i >= 0; i--) if (out[i]) onehot = 4'b0001 << i;
`ifdef WAVE_TOGGLE_OFF_EN
        model_wave = (model_wave == onehot) ? 4'b0000 : onehot;
`else
        model_wave = onehot;
`endif
        sbq.push_back('{cyc: cyc, wave: model_wave});
      end
    end
  end

  always @(negedge sys_clk) begin
    int pending;
    ev_t ev;
    if (!sys_rst_n) begin
      chk("reset_wave_sel", int'(wave_sel), 0);
      chk("reset_key_flag", int'(key_flag), 0);
      sbq.delete();
    end else begin
      chk("wave_sel", int'(wave_sel), int'(model_wave));
      pending = (sbq.size() > 0 && sbq[0].cyc <= cyc) ? 1 : 0;
      chk("key_flag", int'(key_flag), pending);
      if (key_flag) begin
        flag_count++;
        last_flag_cyc = cyc;
      end
      if (pending != 0) begin
        ev = sbq.pop_front();
        if (key_flag) chk("flag_wave", int'(wave_sel), int'(ev.wave));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic drive(input logic [3:0] k, input int n);
    key = k;
    step(n);
  endtask

  initial begin
    int t;
    int f0;
    step(3);
    sys_rst_n = 1'b1;

    // Idle after reset
    drive(4'hF, 100);
    chk("idle_no_flag", flag_count, 0);

    // Single press of key[1]
    f0 = flag_count;
    t  = cyc;
    drive(4'b1101, 50);
    drive(4'hF, 30);
    chk("key1_flags", flag_count - f0, 1);
    chk("key1_latency", last_flag_cyc - t, LAT);
    chk("key1_wave", int'(wave_sel), 2);

    // Glitches on key[2], then a real press
    f0 = flag_count;
    for (int g = 0; g < 13; g++) begin
      drive(4'b1011, 10);
      drive(4'hF, 5);
    end
    chk("glitch_no_flag", flag_count - f0, 0);
    chk("glitch_wave_kept", int'(wave_sel), 2);
    t = cyc;
    drive(4'b1011, 50);
    chk("key2_latency", last_flag_cyc - t, LAT);
    chk("key2_wave", int'(wave_sel), 4);
    drive(4'hF, 30);

    // key[3] and key[0] together
    f0 = flag_count;
    drive(4'b0110, 50);
    drive(4'hF, 30);
    chk("dual_flags", flag_count - f0, 1);
    chk("dual_wave", int'(wave_sel), 1);

    // Re-press of the selected key
    f0 = flag_count;
    drive(4'b1110, 50);
    drive(4'hF, 30);
    chk("repress_flags", flag_count - f0, 1);
`ifdef WAVE_TOGGLE_OFF_EN
    chk("repress_wave", int'(wave_sel), 0);
`else
    chk("repress_wave", int'(wave_sel), 1);
`endif

    // Reset in the middle of a key[2] debounce
    key = 4'b1011;
    step(10);
    sys_rst_n = 1'b0;
    step(5);
    chk("midreset_wave", int'(wave_sel), 0);
    sys_rst_n = 1'b1;
    t = cyc;
    f0 = flag_count;
    step(40);
    chk("midreset_flags", flag_count - f0, 1);
    chk("midreset_latency", last_flag_cyc - t, LAT);
    chk("midreset_wave_after", int'(wave_sel), 4);
    drive(4'hF, 30);

    // Random key patterns against the reference model
    for (int s = 0; s < 80; s++) begin
      drive(4'($urandom_range(0, 15)), $urandom_range(1, 40));
    end
    drive(4'hF, 40);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
